// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Default widths match the 4x4 multiplier product it inverts.
package div_pkg;

  localparam int DW = 8;
  localparam int VW = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_e;

  localparam logic [DW-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division step: shift in the next dividend bit and try to
// subtract the divisor, restoring the shifted remainder on borrow.
module div_trial_sub #(
  parameter int VW = 4
) (
  input  logic [VW:0]   rem,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic          qbit
);

  logic [VW:0]   shifted;
  logic [VW+1:0] diff;
  logic          borrow;

  // A set top remainder bit means the shifted value already exceeds any divisor.
  always_comb begin
    shifted  = {rem[VW-1:0], din};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    borrow   = diff[VW+1] & ~rem[VW];
    qbit     = ~borrow;
    rem_next = borrow ? shifted : diff[VW:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock with
// valid/ready handshakes on operands and result.
module seq_restoring_divider #(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  import div_pkg::*;

  div_state_e    state;
  logic [DW-1:0] q;
  logic [VW-1:0] d;
  logic [VW:0]   r;
  logic [CW-1:0] count;
  logic [VW:0]   r_next;
  logic          q_bit;

  div_trial_sub #(.VW(VW)) trial (
    .rem      (r),
    .din      (q[DW-1]),
    .divisor  (d),
    .rem_next (r_next),
    .qbit     (q_bit)
  );

  assign in_ready = (state == IDLE);

  // Result registers are loaded on the final RUN step so DONE only has to hold them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q <= dividend;
            d <= divisor;
            r <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= DBZ_QUOTIENT;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              count <= CW'(DW);
            end
          end
        end
        RUN: begin
          r     <= r_next;
          q     <= {q[DW-2:0], q_bit};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= {q[DW-2:0], q_bit};
            remainder   <= r_next[VW-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
